// File: rtl/seg_marquee_if.sv
// Name handshake between the song player and the marquee controller.
//   name_valid  source -> sink  name_len/name_chars are valid
//   name_ready  sink -> source  controller can take a name this cycle
//   name_len    source -> sink  character count (clamped by the sink)
//   name_chars  source -> sink  char i at [8i+7:8i], char 0 leftmost
interface seg_marquee_if #(
  parameter int MAX_LEN = 8
);
  logic                   name_valid;
  logic                   name_ready;
  logic [3:0]             name_len;
  logic [8*MAX_LEN-1:0]   name_chars;

  modport master (output name_valid, name_len, name_chars, input name_ready);
  modport slave  (input name_valid, name_len, name_chars, output name_ready);
endinterface

// File: rtl/seg_marquee_ctrl.sv
// Four-digit seven-segment name display sequencer.
// Names of 1-4 chars are shown statically; longer names scroll left with one
// blank separator. The four anodes are time-multiplexed. The block only drives
// the display while mode==ENABLE_MODE; otherwise it blanks and freezes.
//   clk        system clock
//   reset      synchronous, active-low
//   mode       player mode, block enabled when mode==ENABLE_MODE
//   name_if    name handshake (slave side)
//   seg        registered segment pattern {dot,a..g} for the active digit
//   an         registered one-hot digit enable
//   busy       a name is being displayed (state != IDLE)
//   wrap_pulse one-cycle pulse when the scroll offset wraps back to 0
module seg_marquee_ctrl #(
  parameter int          REFRESH_DIV = 200000,
  parameter int          STEP_DIV    = 50000000,
  parameter int          MAX_LEN     = 8,
  parameter logic [2:0]  ENABLE_MODE = 3'b010
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         mode,
  seg_marquee_if.slave       name_if,
  output logic [7:0]         seg,
  output logic [3:0]         an,
  output logic               busy,
  output logic               wrap_pulse
);
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STATIC = 2'd1;
  localparam logic [1:0] SCROLL = 2'd2;

  logic [1:0]              state;
  logic [3:0]              len_q;
  logic [MAX_LEN-1:0][7:0] chars_q;
  logic [3:0]              offset;
  logic [SW-1:0]           step_cnt;
  logic [RW-1:0]           refresh_cnt;
  logic [1:0]              digit;

  logic       en, accept, ref_wrap, step_wrap;
  logic [3:0] len_in;
  logic [4:0] pos;
  logic [7:0] win;

  assign en        = (mode == ENABLE_MODE);
  assign accept    = name_if.name_valid & en;
  assign len_in    = (name_if.name_len > 4'(MAX_LEN)) ? 4'(MAX_LEN) : name_if.name_len;
  assign ref_wrap  = (refresh_cnt == RW'(REFRESH_DIV - 1));
  assign step_wrap = (step_cnt == SW'(STEP_DIV - 1));

  assign name_if.name_ready = en;
  assign busy               = (state != IDLE);

  // Only the digit being refreshed this slot needs its character. Positions
  // at or beyond len are blank, which covers both the static padding and the
  // scroll separator (position == len).
  always_comb begin
    pos = '0;
    win = '0;
    case (state)
      STATIC: pos = {3'b0, digit};
      SCROLL: begin
        pos = {1'b0, offset} + {3'b0, digit};
        // offset <= len and digit <= 3 < period, so one subtraction suffices
        if (pos > {1'b0, len_q}) pos = pos - ({1'b0, len_q} + 5'd1);
      end
      default: pos = '0;
    endcase
    if (state != IDLE) begin
      for (int j = 0; j < MAX_LEN; j++) begin
        if (pos == 5'(j) && 5'(j) < {1'b0, len_q}) win = chars_q[j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      len_q       <= '0;
      chars_q     <= '0;
      offset      <= '0;
      step_cnt    <= '0;
      refresh_cnt <= '0;
      digit       <= '0;
      seg         <= '0;
      an          <= '0;
      wrap_pulse  <= 1'b0;
    end else begin
      wrap_pulse <= 1'b0;
      if (!en) begin
        // Blank the display; everything else holds so display resumes as-is.
        seg <= '0;
        an  <= '0;
      end else begin
        seg         <= win;
        an          <= 4'b0001 << digit;
        refresh_cnt <= ref_wrap ? '0 : refresh_cnt + 1'b1;
        if (ref_wrap) digit <= digit + 1'b1;

        // A new name takes priority over a coincident scroll step.
        if (accept) begin
          chars_q  <= name_if.name_chars;
          len_q    <= len_in;
          offset   <= '0;
          step_cnt <= '0;
          if (len_in == 4'd0)      state <= IDLE;
          else if (len_in <= 4'd4) state <= STATIC;
          else                     state <= SCROLL;
        end else if (state == SCROLL) begin
          if (step_wrap) begin
            step_cnt <= '0;
            if (offset == len_q) begin
              offset     <= '0;
              wrap_pulse <= 1'b1;
            end else begin
              offset <= offset + 1'b1;
            end
          end else begin
            step_cnt <= step_cnt + 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_seg_marquee_ctrl.sv
module tb_seg_marquee_ctrl;
  localparam int RD = 4;
  localparam int SD = 16;
  localparam int ML = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] mode = 3'b010;
  logic [7:0] seg;
  logic [3:0] an;
  logic       busy, wrap_pulse;

  seg_marquee_if #(.MAX_LEN(ML)) nif ();

  seg_marquee_ctrl #(.REFRESH_DIV(RD), .STEP_DIV(SD), .MAX_LEN(ML), .ENABLE_MODE(3'b010)) dut (
    .clk(clk), .reset(reset), .mode(mode), .name_if(nif),
    .seg(seg), .an(an), .busy(busy), .wrap_pulse(wrap_pulse)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct { logic [7:0] seg; logic [3:0] an; logic wrap; logic busy; } exp_t;
  exp_t q[$];

  typedef struct { logic [2:0] mode; logic [3:0] an; logic [7:0] seg; } vec_t;
  vec_t tbl[16];

  // reference model: 0 idle, 1 static, 2 scroll
  int         m_state, m_len, m_off, m_step, m_ref, m_dig;
  logic [7:0] m_chars[ML];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_win();
    int p;
    if (m_state == 1) return (m_dig < m_len) ? m_chars[m_dig] : 8'h00;
    if (m_state == 2) begin
      p = (m_off + m_dig) % (m_len + 1);
      return (p == m_len) ? 8'h00 : m_chars[p];
    end
    return 8'h00;
  endfunction

  // One clock: predict outputs from current inputs, push, clock, pop, compare.
  task automatic tick();
    exp_t e;
    bit   en, acc;
    int   l;
    en = (mode == 3'b010);
    acc = en && nif.name_valid;
    e.seg = 8'h00; e.an = 4'h0; e.wrap = 1'b0;
    if (!reset) begin
      m_state = 0; m_len = 0; m_off = 0; m_step = 0; m_ref = 0; m_dig = 0;
      for (int i = 0; i < ML; i++) m_chars[i] = 8'h00;
    end else if (en) begin
      e.seg  = m_win();
      e.an   = 4'(1 << m_dig);
      e.wrap = (m_state == 2 && !acc && m_step == SD - 1 && m_off == m_len);
      m_ref++;
      if (m_ref == RD) begin m_ref = 0; m_dig = (m_dig + 1) % 4; end
      if (acc) begin
        l = (int'(nif.name_len) > ML) ? ML : int'(nif.name_len);
        m_len = l;
        for (int i = 0; i < ML; i++) m_chars[i] = nif.name_chars[8*i +: 8];
        m_off = 0; m_step = 0;
        m_state = (l == 0) ? 0 : ((l <= 4) ? 1 : 2);
      end else if (m_state == 2) begin
        m_step++;
        if (m_step == SD) begin m_step = 0; m_off = (m_off + 1) % (m_len + 1); end
      end
    end
    e.busy = (m_state != 0);
    q.push_back(e);
    @(posedge clk); #1;
    e = q.pop_front();
    chk("seg", seg, e.seg);
    chk("an", an, e.an);
    chk("wrap_pulse", wrap_pulse, e.wrap);
    chk("busy", busy, e.busy);
    chk("name_ready", nif.name_ready, (mode == 3'b010) ? 1 : 0);
  endtask

  task automatic load(input int len, input logic [8*ML-1:0] ch);
    nif.name_valid = 1'b1;
    nif.name_len   = 4'(len);
    nif.name_chars = ch;
    tick();
    nif.name_valid = 1'b0;
  endtask

  initial begin
    int wraps, wrap_at, n;
    logic [7:0] s1;

    for (int i = 0; i < 16; i++) begin
      tbl[i].mode = 3'b010;
      if (i < 3)       begin tbl[i].an = 4'b0001; tbl[i].seg = 8'h49; end
      else if (i < 7)  begin tbl[i].an = 4'b0010; tbl[i].seg = 8'h0F; end
      else if (i < 11) begin tbl[i].an = 4'b0100; tbl[i].seg = 8'h77; end
      else if (i < 15) begin tbl[i].an = 4'b1000; tbl[i].seg = 8'h46; end
      else             begin tbl[i].an = 4'b0001; tbl[i].seg = 8'h49; end
    end

    nif.name_valid = 1'b0;
    nif.name_len   = 4'd0;
    nif.name_chars = '0;

    // 1. reset state
    tick(); tick();
    chk("rst_seg", seg, 0); chk("rst_an", an, 0); chk("rst_busy", busy, 0);
    chk("rst_wrap", wrap_pulse, 0); chk("rst_ready", nif.name_ready, 1);
    reset = 1'b1;

    // 2. static "STAR"
    load(4, {32'h0, 8'h46, 8'h77, 8'h0F, 8'h49});
    for (int i = 0; i < 16; i++) begin
      mode = tbl[i].mode;
      tick();
      chk("tbl_an", an, tbl[i].an);
      chk("tbl_seg", seg, tbl[i].seg);
    end

    // 3. scroll, len 6: first step shows char 1 at digit 0, wrap after 7 steps
    load(6, {16'h0, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F});
    wraps = 0; wrap_at = 0; s1 = 8'h00;
    for (int k = 1; k <= 112; k++) begin
      tick();
      if (wrap_pulse) begin wraps++; wrap_at = k; end
      if (k >= 17 && k <= 32 && an == 4'b0001) s1 = seg;
    end
    chk("scroll_char1", s1, 8'h06);
    chk("scroll_wraps", wraps, 1);
    chk("scroll_wrap_at", wrap_at, 112);

    // 4. mode gating freezes and blanks, then resumes
    repeat (20) tick();
    mode = 3'b000;
    tick();
    chk("gate_seg", seg, 0); chk("gate_an", an, 0); chk("gate_ready", nif.name_ready, 0);
    repeat (49) tick();
    mode = 3'b010;
    repeat (40) tick();

    // 5. accept on the very step that would wrap the offset
    n = 0;
    while (!(m_state == 2 && m_step == SD - 1 && m_off == m_len) && n < 300) begin
      tick(); n++;
    end
    chk("sync_found", (n < 300) ? 1 : 0, 1);
    load(5, {24'h0, 8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C});
    chk("coinc_no_wrap", wrap_pulse, 0);
    repeat (40) tick();

    // len 0 -> idle, blank
    load(0, {8{8'hFF}});
    repeat (8) tick();
    chk("len0_busy", busy, 0); chk("len0_seg", seg, 0);

    // len 12 clamps to 8: period 9, wrap after 9 steps
    load(12, {8'h7F, 8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06});
    wraps = 0; wrap_at = 0;
    for (int k = 1; k <= 144; k++) begin
      tick();
      if (wrap_pulse) begin wraps++; wrap_at = k; end
    end
    chk("clamp_wraps", wraps, 1);
    chk("clamp_wrap_at", wrap_at, 144);

    // 6. reset mid-scroll
    repeat (30) tick();
    reset = 1'b0;
    tick();
    chk("mid_rst_seg", seg, 0); chk("mid_rst_an", an, 0); chk("mid_rst_busy", busy, 0);
    reset = 1'b1;
    repeat (8) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
